// File: rtl/ram_stream_pkg.sv
// Shared types and constants for the RAM-to-stream burst reader.
// Holds the FSM state enum, default bus widths and the FIFO credit rule.
// The credit rule bounds FIFO entries plus outstanding RAM reads to FIFO_DEPTH.
package ram_stream_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 2;

  localparam logic [CNT_W:0] DEPTH_LIMIT = FIFO_DEPTH[CNT_W:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // True when one more read can be issued without overflowing the FIFO:
  // slots already used (stored + in flight) minus the slot freed this cycle.
  function automatic logic credit_ok(input logic [CNT_W-1:0] count,
                                     input logic             inflight,
                                     input logic             pop);
    logic [CNT_W:0] used;
    logic [CNT_W:0] limit;
    used  = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    limit = DEPTH_LIMIT + {{CNT_W{1'b0}}, pop};
    return used < limit;
  endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry FIFO whose head register drives the output stream directly.
// Latency: a push becomes visible at the head on the following cycle.
// Backpressure: head holds while not popped; the caller never pushes when full.
module stream_fifo2
  import ram_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [CNT_W-1:0]  count,
  output logic              head_valid,
  output logic [DATA_W-1:0] head_data
);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] tail_data;
  logic              pop_ok;

  assign head_valid = (count != CNT_ZERO);
  assign pop_ok     = pop && head_valid;

  // Shift-register FIFO: head is the oldest entry, tail the second one.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= CNT_ZERO;
      head_data <= '0;
      tail_data <= '0;
    end else begin
      unique case ({push, pop_ok})
        2'b10: begin
          if (count == CNT_ZERO) begin
            head_data <= push_data;
          end else begin
            tail_data <= push_data;
          end
          count <= count + CNT_ONE;
        end
        2'b01: begin
          head_data <= tail_data;
          count     <= count - CNT_ONE;
        end
        2'b11: begin
          if (count == CNT_ONE) begin
            head_data <= push_data;
          end else begin
            head_data <= tail_data;
            tail_data <= push_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Reads a burst of words from a synchronous-read RAM and streams them out.
// Latency: start at edge 0, first address in cycle 1, first beat valid in cycle 3.
// Backpressure: m_ready low stalls reads once FIFO plus in-flight reads reach 2.
module ram_stream_reader
  import ram_stream_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] doutb,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W-1:0] last_addr;   // address of the most recent read
  logic [ADDR_W-1:0] next_addr;   // address the next read will use
  logic [ADDR_W:0]   reads_left;  // reads still to issue in this burst
  logic [ADDR_W:0]   beats_left;  // beats still to hand downstream
  logic              inflight;    // a read was issued last cycle; doutb is ours now
  logic              issue;
  logic              pop;
  logic [CNT_W-1:0]  fifo_count;

  assign pop   = m_valid && m_ready;
  // Reset gates issue so nothing launched during reset is ever counted.
  assign issue = (state == RUN) && !rst && credit_ok(fifo_count, inflight, pop);
  // The RAM samples addrb every edge; between reads it just re-reads the last word.
  assign addrb = issue ? next_addr : last_addr;
  assign busy  = (state != IDLE);

  // Burst control: capture request, walk addresses, count beats, pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_addr  <= '0;
      next_addr  <= '0;
      reads_left <= '0;
      beats_left <= '0;
      inflight   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;

      if (issue) begin
        last_addr  <= next_addr;
        next_addr  <= next_addr + ADDR_ONE;
        reads_left <= reads_left - LEN_ONE;
      end

      if (pop) begin
        beats_left <= beats_left - LEN_ONE;
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              state      <= RUN;
              next_addr  <= base_addr;
              reads_left <= len;
              beats_left <= len;
            end
          end
        end
        RUN: begin
          if (issue && (reads_left == LEN_ONE)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && (beats_left == LEN_ONE)) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  stream_fifo2 #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (doutb),
    .pop       (pop),
    .count     (fifo_count),
    .head_valid(m_valid),
    .head_data (m_data)
  );

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: behavioural synchronous RAM preloaded with i+0x100,
// cycle-by-cycle vector table for the ready-high bursts, and a hand-written
// stall sequence with a small scoreboard for the backpressure case.
module tb_ram_stream_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  base_addr;
  logic [6:0]  len;
  logic [5:0]  addrb;
  logic [31:0] doutb;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  ram_stream_reader #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .len      (len),
    .addrb    (addrb),
    .doutb    (doutb),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM: data for the address sampled at an edge appears after it.
  logic [31:0] mem [0:63];
  initial for (int i = 0; i < 64; i++) mem[i] = 32'h100 + i;
  always @(posedge clk) doutb <= mem[addrb];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          chk;
    bit          rst;
    bit          start;
    logic [5:0]  base;
    logic [6:0]  len;
    bit          rdy;
    logic [5:0]  e_addrb;
    bit          e_valid;
    logic [31:0] e_data;
    bit          e_busy;
    bit          e_done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int chk, input int r, input int st, input int b,
                              input int l, input int rdy, input int ea, input int ev,
                              input int ed, input int eb, input int edn);
    vec_t v;
    v.chk = chk[0]; v.rst = r[0]; v.start = st[0]; v.base = b[5:0]; v.len = l[6:0];
    v.rdy = rdy[0]; v.e_addrb = ea[5:0]; v.e_valid = ev[0]; v.e_data = ed[31:0];
    v.e_busy = eb[0]; v.e_done = edn[0];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  int          issued;
  int          accepted;
  int          dones;
  bit          stalled;
  logic [31:0] held;
  logic [5:0]  last_a;

  initial begin
    // Columns: chk rst start base len rdy | addrb valid data busy done
    // Burst base=4 len=3 started the first cycle after reset releases.
    tbl.push_back(mk(1,0,1, 4,3,1,  0,0,0,     0,0));
    tbl.push_back(mk(1,0,0, 0,0,1,  4,0,0,     1,0));
    tbl.push_back(mk(1,0,0, 0,0,1,  5,0,0,     1,0));
    tbl.push_back(mk(1,0,0, 0,0,1,  6,1,'h104, 1,0));
    tbl.push_back(mk(1,0,0, 0,0,1,  6,1,'h105, 1,0));
    tbl.push_back(mk(1,0,0, 0,0,1,  6,1,'h106, 1,0));
    tbl.push_back(mk(1,0,0, 0,0,1,  6,0,0,     0,1));
    // Burst base=62 len=4: addresses wrap 63 -> 0.
    tbl.push_back(mk(1,0,1,62,4,1,  6,0,0,     0,0));
    tbl.push_back(mk(1,0,0, 0,0,1, 62,0,0,     1,0));
    tbl.push_back(mk(1,0,0, 0,0,1, 63,0,0,     1,0));
    tbl.push_back(mk(1,0,0, 0,0,1,  0,1,'h13E, 1,0));
    tbl.push_back(mk(1,0,0, 0,0,1,  1,1,'h13F, 1,0));
    tbl.push_back(mk(1,0,0, 0,0,1,  1,1,'h100, 1,0));
    tbl.push_back(mk(1,0,0, 0,0,1,  1,1,'h101, 1,0));
    tbl.push_back(mk(1,0,0, 0,0,1,  1,0,0,     0,1));
    // len=0: no read, never busy, done the next cycle.
    tbl.push_back(mk(1,0,1,33,0,1,  1,0,0,     0,0));
    tbl.push_back(mk(1,0,0, 0,0,1,  1,0,0,     0,1));
    tbl.push_back(mk(1,0,0, 0,0,1,  1,0,0,     0,0));
    // Burst base=40 len=2 with a competing start (base=10 len=2) while busy.
    tbl.push_back(mk(1,0,1,40,2,1,  1,0,0,     0,0));
    tbl.push_back(mk(1,0,1,10,2,1, 40,0,0,     1,0));
    tbl.push_back(mk(1,0,1,10,2,1, 41,0,0,     1,0));
    tbl.push_back(mk(1,0,0, 0,0,1, 41,1,'h128, 1,0));
    tbl.push_back(mk(1,0,0, 0,0,1, 41,1,'h129, 1,0));
    tbl.push_back(mk(1,0,0, 0,0,1, 41,0,0,     0,1));
    // len=6 burst aborted by reset after its second beat, then base=20 len=1.
    tbl.push_back(mk(1,0,1,30,6,1, 41,0,0,     0,0));
    tbl.push_back(mk(1,0,0, 0,0,1, 30,0,0,     1,0));
    tbl.push_back(mk(1,0,0, 0,0,1, 31,0,0,     1,0));
    tbl.push_back(mk(1,0,0, 0,0,1, 32,1,'h11E, 1,0));
    tbl.push_back(mk(1,0,0, 0,0,1, 33,1,'h11F, 1,0));
    tbl.push_back(mk(0,1,0, 0,0,1,  0,0,0,     0,0));
    tbl.push_back(mk(1,0,1,20,1,1,  0,0,0,     0,0));
    tbl.push_back(mk(1,0,0, 0,0,1, 20,0,0,     1,0));
    tbl.push_back(mk(1,0,0, 0,0,1, 20,0,0,     1,0));
    tbl.push_back(mk(1,0,0, 0,0,1, 20,1,'h114, 1,0));
    tbl.push_back(mk(1,0,0, 0,0,1, 20,0,0,     0,1));
    tbl.push_back(mk(1,0,0, 0,0,1, 20,0,0,     0,0));

    // Reset and check the reset state.
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset m_valid", 32'(m_valid), 0);
    check("reset m_data",  m_data,       0);
    check("reset addrb",   32'(addrb),   0);
    check("reset busy",    32'(busy),    0);
    check("reset done",    32'(done),    0);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst       = tbl[i].rst;
      start     = tbl[i].start;
      base_addr = tbl[i].base;
      len       = tbl[i].len;
      m_ready   = tbl[i].rdy;
      #1;
      if (tbl[i].chk) begin
        check($sformatf("row%0d addrb", i),   32'(addrb),   32'(tbl[i].e_addrb));
        check($sformatf("row%0d m_valid", i), 32'(m_valid), 32'(tbl[i].e_valid));
        if (tbl[i].e_valid)
          check($sformatf("row%0d m_data", i), m_data, tbl[i].e_data);
        check($sformatf("row%0d busy", i),    32'(busy),    32'(tbl[i].e_busy));
        check($sformatf("row%0d done", i),    32'(done),    32'(tbl[i].e_done));
      end
    end

    // Stall sequence: base=0 len=8, m_ready pattern 1,0,0,1 per cycle.
    issued = 0; accepted = 0; dones = 0; stalled = 1'b0; held = '0; last_a = '0;
    for (int cyc = 0; cyc < 300 && dones == 0; cyc++) begin
      @(negedge clk);
      start     = (cyc == 0);
      base_addr = 6'd0;
      len       = 7'd8;
      m_ready   = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      #1;
      if (cyc == 0) begin
        last_a = addrb;
      end else if (addrb != last_a) begin
        check("stall addr order", 32'(addrb), 32'(issued));
        issued++;
        last_a = addrb;
      end
      if (stalled) begin
        check("stall valid held", 32'(m_valid), 1);
        check("stall data held",  m_data,       held);
      end
      if (m_valid && m_ready) begin
        check("stall beat data", m_data, 32'h100 + 32'(accepted));
        accepted++;
      end
      check("stall occupancy<=2", 32'((issued - accepted) <= 2), 1);
      if (done) dones++;
      stalled = m_valid && !m_ready;
      held    = m_data;
    end
    check("stall reads issued",   32'(issued),   8);
    check("stall beats accepted", 32'(accepted), 8);
    check("stall done pulses",    32'(dones),    1);
    @(negedge clk);
    #1;
    check("stall end busy",    32'(busy),    0);
    check("stall end done",    32'(done),    0);
    check("stall end m_valid", 32'(m_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
